// File: rtl/sev_seg_scan_ctrl.sv
// Scan scheduler for a shared 4-digit common-anode seven-segment display.
// Time-multiplexes one segment bus across four digits, puts an all-off gap
// ahead of every digit slot, and freezes the digit data once per frame.
module sev_seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV  = 32768,
    parameter int unsigned BLANK_CYC = 256
) (
    input  logic       clk_main,
    input  logic       reset,
    input  logic [3:0] num_1,
    input  logic [3:0] num_2,
    input  logic [3:0] num_3,
    input  logic [3:0] num_4,
    input  logic [3:0] dp_in,
    input  logic [3:0] digit_blank,
    input  logic       lz_suppress,
    output logic [7:0] sev_seg_leds,
    output logic [3:0] led_enable,
    output logic       frame_done
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned NUM_DIG = 4;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DRIVE_BEG = CNT_W'(BLANK_CYC);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_e;

    // Active-low segment pattern (bits g..a) for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] val);
        logic [6:0] seg;
        unique case (val)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       dig_idx_q, dig_idx_d;

    logic [3:0]       sh_num_q [NUM_DIG];
    logic [3:0]       sh_dp_q;
    logic [3:0]       sh_blank_q;
    logic             sh_lz_q;

    logic [7:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_done_q, frame_done_d;

    logic             frame_start_c;
    logic [3:0]       dark_c;

    // Shadows load on the first clock of digit 0's slot
    assign frame_start_c = (slot_cnt_q == '0) && (dig_idx_q == 2'd0);

    // Per-digit dark flags from shadowed data: forced blank or leading zero
    always_comb begin
        dark_c    = sh_blank_q;
        dark_c[3] = sh_blank_q[3] | (sh_lz_q & (sh_num_q[3] == 4'h0));
        dark_c[2] = sh_blank_q[2] | (sh_lz_q & (sh_num_q[3] == 4'h0)
                                             & (sh_num_q[2] == 4'h0));
        dark_c[1] = sh_blank_q[1] | (sh_lz_q & (sh_num_q[3] == 4'h0)
                                             & (sh_num_q[2] == 4'h0)
                                             & (sh_num_q[1] == 4'h0));
    end

    // Slot counter, digit index and BLANK/DRIVE next-state
    always_comb begin
        slot_cnt_d = slot_cnt_q + CNT_W'(1);
        dig_idx_d  = dig_idx_q;
        state_d    = state_q;
        if (slot_cnt_q == SLOT_LAST) begin
            slot_cnt_d = '0;
            dig_idx_d  = dig_idx_q + 2'd1;
            state_d    = ST_BLANK;
        end else if (slot_cnt_d == DRIVE_BEG) begin
            state_d    = ST_DRIVE;
        end
    end

    // Output decode from the current state; registered one clock later
    always_comb begin
        seg_d        = 8'hFF;
        an_d         = 4'hF;
        frame_done_d = (slot_cnt_q == SLOT_LAST) && (dig_idx_q == 2'd3);
        if ((state_q == ST_DRIVE) && !dark_c[dig_idx_q]) begin
            an_d  = ~(4'b0001 << dig_idx_q);
            seg_d = {~sh_dp_q[dig_idx_q], hex_to_seg(sh_num_q[dig_idx_q])};
        end
    end

    // Scan state registers
    always_ff @(posedge clk_main) begin
        if (reset) begin
            state_q    <= ST_BLANK;
            slot_cnt_q <= '0;
            dig_idx_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            slot_cnt_q <= slot_cnt_d;
            dig_idx_q  <= dig_idx_d;
        end
    end

    // Frame-coherent shadow copies of all digit inputs
    always_ff @(posedge clk_main) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIG; i++) begin
                sh_num_q[i] <= 4'h0;
            end
            sh_dp_q    <= 4'h0;
            sh_blank_q <= 4'h0;
            sh_lz_q    <= 1'b0;
        end else if (frame_start_c) begin
            sh_num_q[0] <= num_1;
            sh_num_q[1] <= num_2;
            sh_num_q[2] <= num_3;
            sh_num_q[3] <= num_4;
            sh_dp_q     <= dp_in;
            sh_blank_q  <= digit_blank;
            sh_lz_q     <= lz_suppress;
        end
    end

    // Registered display outputs; segments and anodes move on the same edge
    always_ff @(posedge clk_main) begin
        if (reset) begin
            seg_q        <= 8'hFF;
            an_q         <= 4'hF;
            frame_done_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sev_seg_leds = seg_q;
    assign led_enable   = an_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_sev_seg_scan_ctrl.sv
// Self-checking bench for sev_seg_scan_ctrl (SCAN_DIV=8, BLANK_CYC=2).
module tb_sev_seg_scan_ctrl;

    localparam int unsigned SDIV  = 8;
    localparam int unsigned BLNK  = 2;
    localparam int unsigned FRAME = 4 * SDIV;

    logic       clk_main = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] num_1 = 4'h0, num_2 = 4'h0, num_3 = 4'h0, num_4 = 4'h0;
    logic [3:0] dp_in = 4'h0, digit_blank = 4'h0;
    logic       lz_suppress = 1'b0;
    logic [7:0] sev_seg_leds;
    logic [3:0] led_enable;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    sev_seg_scan_ctrl #(.SCAN_DIV(SDIV), .BLANK_CYC(BLNK)) dut (
        .clk_main    (clk_main),
        .reset       (reset),
        .num_1       (num_1),
        .num_2       (num_2),
        .num_3       (num_3),
        .num_4       (num_4),
        .dp_in       (dp_in),
        .digit_blank (digit_blank),
        .lz_suppress (lz_suppress),
        .sev_seg_leds(sev_seg_leds),
        .led_enable  (led_enable),
        .frame_done  (frame_done)
    );

    always #5 clk_main = ~clk_main;

    // Full 8-bit cathode patterns with dp off, 0..F
    logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural reference model ----------------
    // pos = position in the frame (0..31) of the state the DUT now holds.
    int         pos = 0;
    bit         model_on = 0;
    int         m_num [4];
    bit [3:0]   m_dp, m_blk;
    bit         m_lz;
    logic [7:0] e_seg;
    logic [3:0] e_an;
    logic       e_fd;

    function automatic bit model_dark(input int d);
        bit zeros = 1;
        if (m_blk[d]) return 1;
        if (!m_lz || d == 0) return 0;
        for (int j = d; j < 4; j++) if (m_num[j] != 0) zeros = 0;
        return zeros;
    endfunction

    always @(posedge clk_main) begin
        if (reset) begin
            e_seg = 8'hFF; e_an = 4'hF; e_fd = 1'b0;
            pos = 0;
            for (int k = 0; k < 4; k++) m_num[k] = 0;
            m_dp = 0; m_blk = 0; m_lz = 0;
            model_on = 1;
        end else begin
            int slot, dig;
            slot  = pos % SDIV;
            dig   = pos / SDIV;
            e_seg = 8'hFF; e_an = 4'hF;
            e_fd  = (pos == FRAME - 1);
            if (slot >= BLNK && !model_dark(dig)) begin
                e_an  = 4'hF ^ (4'h1 << dig);
                e_seg = hex_tbl[m_num[dig]] & (m_dp[dig] ? 8'h7F : 8'hFF);
            end
            if (pos == 0) begin
                m_num[0] = num_1; m_num[1] = num_2; m_num[2] = num_3; m_num[3] = num_4;
                m_dp = dp_in; m_blk = digit_blank; m_lz = lz_suppress;
            end
            pos = (pos + 1) % FRAME;
        end
        #1;
        if (model_on) begin
            chk("model_seg", 32'(sev_seg_leds), 32'(e_seg));
            chk("model_an", 32'(led_enable), 32'(e_an));
            chk("model_fd", 32'(frame_done), 32'(e_fd));
            chk("one_anode", 32'($countones(~led_enable) <= 1), 32'd1);
        end
    end

    // ---------------- Helpers ----------------
    task automatic wait_pos(input int p, input string nm);
        int n = 0;
        @(negedge clk_main);
        while (pos != p && n < 4 * FRAME) begin
            @(negedge clk_main);
            n++;
        end
        if (pos != p) begin
            errors++;
            $display("FAIL %s: timeout waiting for frame position %0d", nm, p);
        end
    endtask

    task automatic check_digit(input int d, input logic [7:0] seg, input logic [3:0] an,
                               input string nm);
        wait_pos(d * SDIV + 5, nm);
        chk({nm, "_seg"}, 32'(sev_seg_leds), 32'(seg));
        chk({nm, "_an"}, 32'(led_enable), 32'(an));
    endtask

    task automatic set_nums(input logic [15:0] n);
        {num_4, num_3, num_2, num_1} = n;
    endtask

    typedef struct {
        logic [15:0] nums;
        logic [3:0]  dp;
        logic [3:0]  blk;
        logic        lz;
        logic [31:0] segs;
        logic [15:0] ans;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int t_prev, t_now, n;
        logic [7:0] sexp;

        vecs[0] = '{16'h0050, 4'h0, 4'h0, 1'b1, 32'hFFFF_92C0, 16'hFFDE};
        vecs[1] = '{16'h0050, 4'h0, 4'h0, 1'b0, 32'hC0C0_92C0, 16'h7BDE};
        vecs[2] = '{16'h1234, 4'h0, 4'h2, 1'b0, 32'hF9A4_FF99, 16'h7BFE};
        vecs[3] = '{16'h0000, 4'h1, 4'h0, 1'b1, 32'hFFFF_FF40, 16'hFFFE};
        vecs[4] = '{16'hABCD, 4'hA, 4'h0, 1'b0, 32'h0883_46A1, 16'h7BDE};
        vecs[5] = '{16'h0F00, 4'h0, 4'h0, 1'b1, 32'hFF8E_C0C0, 16'hFBDE};
        vecs[6] = '{16'hE987, 4'h4, 4'h9, 1'b0, 32'hFF10_80FF, 16'hFBDF};

        // Reset held for 3 clocks: outputs idle
        repeat (3) begin
            @(posedge clk_main); #2;
            chk("rst_seg", 32'(sev_seg_leds), 32'hFF);
            chk("rst_an", 32'(led_enable), 32'hF);
            chk("rst_fd", 32'(frame_done), 32'h0);
        end
        @(negedge clk_main);
        reset = 1'b0;

        // Scan order: first anode low appears 3 clocks after release, on digit 0
        repeat (2) @(posedge clk_main);
        #2 chk("gap_an", 32'(led_enable), 32'hF);
        @(posedge clk_main); #2 chk("first_an", 32'(led_enable), 32'hE);

        // frame_done period
        n = 0; t_prev = -1; t_now = -1;
        while (t_now < 0 && n < 4 * FRAME) begin
            @(negedge clk_main);
            if (frame_done) begin
                if (t_prev < 0) t_prev = n; else t_now = n;
            end
            n++;
        end
        chk("fd_period", 32'(t_now - t_prev), 32'(FRAME));

        // Table-driven frame vectors
        foreach (vecs[v]) begin
            @(negedge clk_main);
            set_nums(vecs[v].nums);
            dp_in = vecs[v].dp; digit_blank = vecs[v].blk; lz_suppress = vecs[v].lz;
            wait_pos(1, "vec_latch");
            for (int d = 0; d < 4; d++)
                check_digit(d, vecs[v].segs[d*8 +: 8], vecs[v].ans[d*4 +: 4],
                            $sformatf("vec%0d_d%0d", v, d));
        end

        // Decode sweep on digit 0
        digit_blank = 4'h0; lz_suppress = 1'b0; dp_in = 4'h0;
        for (int h = 0; h < 16; h++) begin
            @(negedge clk_main);
            num_1 = 4'(h);
            wait_pos(1, "sweep_latch");
            check_digit(0, hex_tbl[h], 4'hE, $sformatf("sweep_%0h", h));
        end

        // Frame coherence: num_3 changes during digit 1's slot
        @(negedge clk_main);
        set_nums(16'h0300);
        wait_pos(1, "coh_latch");
        wait_pos(SDIV + 3, "coh_mid");
        num_3 = 4'h7;
        check_digit(2, 8'hB0, 4'hB, "coh_cur");
        wait_pos(1, "coh_latch2");
        check_digit(2, 8'hF8, 4'hB, "coh_next");

        // Reset mid-DRIVE of digit 2
        wait_pos(2 * SDIV + 4, "rst_mid");
        chk("pre_rst_an", 32'(led_enable), 32'hB);
        reset = 1'b1;
        set_nums(16'h0006);
        @(posedge clk_main); #2;
        chk("mid_rst_seg", 32'(sev_seg_leds), 32'hFF);
        chk("mid_rst_an", 32'(led_enable), 32'hF);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        @(negedge clk_main);
        reset = 1'b0;
        check_digit(0, 8'h82, 4'hE, "post_rst_d0");

        // Randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            @(negedge clk_main);
            set_nums(16'($urandom));
            dp_in = 4'($urandom); digit_blank = 4'($urandom & $urandom);
            lz_suppress = 1'($urandom);
            if ($urandom_range(0, 3) == 0) set_nums(16'($urandom_range(0, 255)));
            repeat ($urandom_range(1, 40)) @(negedge clk_main);
        end
        repeat (FRAME) @(negedge clk_main);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
